control_pipe: RTL and testbench

Parametrised pipelined main-control unit for the 5-stage MIPS core. Decodes the ID-stage opcode into EX/M/WB control bundles. Carries those bundles through the ID/EX, EX/MEM and MEM/WB pipeline registers. Adds load-use hazard detection with bubble insertion, branch/jump flush, BNE/LUI support, a widened ALUOp code and illegal-opcode detection. All don't-care decode values resolve to 0.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/control_decode.sv | 81 ++++++++
 rtl/control_pipe.sv | 100 ++++++++++
 tb/tb_control_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, ALUOp and control-bundle layout definitions for the MIPS
// main-control pipeline.
package ctrl_pkg;

   localparam int EX_W = 5;
   localparam int M_W  = 5;
   localparam int WB_W = 2;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_FUNCT = 3'b010,
      ALU_SLT   = 3'b011,
      ALU_OR    = 3'b100,
      ALU_AND   = 3'b101,
      ALU_LUI   = 3'b110
   } alu_op_e;

   // ex = {RegDst, ALUOp[2:0], ALUSrc}
   localparam int EX_REGDST   = 4;
   localparam int EX_ALUOP_HI = 3;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_ALUSRC   = 0;

   // m = {Branch, BranchNe, MemRead, MemWrite, Jump}
   localparam int M_BRANCH   = 4;
   localparam int M_BRANCHNE = 3;
   localparam int M_MEMREAD  = 2;
   localparam int M_MEMWRITE = 1;
   localparam int M_JUMP     = 0;

   // wb = {RegWrite, MemtoReg}
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: produces the EX/M/WB control bundles plus
// legality and register-source usage flags.
module control_decode
   import ctrl_pkg::*;
(
   input  logic [5:0]      i_op,
   output logic [EX_W-1:0] o_ex,
   output logic [M_W-1:0]  o_m,
   output logic [WB_W-1:0] o_wb,
   output logic            o_legal,
   output logic            o_uses_rs,
   output logic            o_uses_rt
);

   always_comb begin
      o_ex      = '0;
      o_m       = '0;
      o_wb      = '0;
      o_legal   = 1'b1;
      o_uses_rs = 1'b1;
      o_uses_rt = 1'b0;
      unique case (i_op)
         OP_R: begin
            o_ex      = {1'b1, ALU_FUNCT, 1'b0};
            o_wb      = 2'b10;
            o_uses_rt = 1'b1;
         end
         OP_LW: begin
            o_ex = {1'b0, ALU_ADD, 1'b1};
            o_m  = 5'b00100;
            o_wb = 2'b11;
         end
         OP_SW: begin
            o_ex      = {1'b0, ALU_ADD, 1'b1};
            o_m       = 5'b00010;
            o_uses_rt = 1'b1;
         end
         OP_BEQ: begin
            o_ex      = {1'b0, ALU_SUB, 1'b0};
            o_m       = 5'b10000;
            o_uses_rt = 1'b1;
         end
         OP_BNE: begin
            o_ex      = {1'b0, ALU_SUB, 1'b0};
            o_m       = 5'b11000;
            o_uses_rt = 1'b1;
         end
         OP_ADDI: begin
            o_ex = {1'b0, ALU_ADD, 1'b1};
            o_wb = 2'b10;
         end
         OP_SLTI: begin
            o_ex = {1'b0, ALU_SLT, 1'b1};
            o_wb = 2'b10;
         end
         OP_ANDI: begin
            o_ex = {1'b0, ALU_AND, 1'b1};
            o_wb = 2'b10;
         end
         OP_ORI: begin
            o_ex = {1'b0, ALU_OR, 1'b1};
            o_wb = 2'b10;
         end
         OP_LUI: begin
            o_ex      = {1'b0, ALU_LUI, 1'b1};
            o_wb      = 2'b10;
            o_uses_rs = 1'b0;
         end
         OP_J: begin
            o_m       = 5'b00001;
            o_uses_rs = 1'b0;
         end
         default: begin
            // Unknown opcodes decode to a bubble and read no registers
            o_legal   = 1'b0;
            o_uses_rs = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/control_pipe.sv
// Pipelined main control: decodes in ID and carries the control bundles
// through ID/EX, EX/MEM and MEM/WB, with load-use stall and flush handling.
module control_pipe
   import ctrl_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter bit HAZARD_EN = 1'b1,
   parameter bit FLUSH_EX  = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [5:0]        id_op,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              flush,
   output logic [EX_W-1:0]   ex_ctrl,
   output logic [M_W-1:0]    mem_ctrl,
   output logic [WB_W-1:0]   wb_ctrl,
   output logic              stall,
   output logic              ill_op
);

   logic [EX_W-1:0] w_ex;
   logic [M_W-1:0]  w_m;
   logic [WB_W-1:0] w_wb;
   logic            w_legal;
   logic            w_uses_rs;
   logic            w_uses_rt;
   logic            w_src_match;
   logic            w_hazard;
   logic            w_bubble;

   logic [EX_W-1:0] r_ex_p1;
   logic [M_W-1:0]  r_m_p1;
   logic [WB_W-1:0] r_wb_p1;
   logic [M_W-1:0]  r_m_p2;
   logic [WB_W-1:0] r_wb_p2;
   logic [WB_W-1:0] r_wb_p3;
   logic            r_ill_p1;

   control_decode u_decode (
      .i_op      (id_op),
      .o_ex      (w_ex),
      .o_m       (w_m),
      .o_wb      (w_wb),
      .o_legal   (w_legal),
      .o_uses_rs (w_uses_rs),
      .o_uses_rt (w_uses_rt)
   );

   assign w_src_match = (w_uses_rs && (ex_rt == id_rs)) ||
                        (w_uses_rt && (ex_rt == id_rt));
   // Only a load sitting in ID/EX can cause a one-bubble load-use stall
   assign w_hazard = HAZARD_EN && id_valid && r_m_p1[M_MEMREAD] &&
                     (ex_rt != '0) && w_src_match;
   assign w_bubble = flush || w_hazard || !id_valid;
   assign stall    = w_hazard && !flush && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_p1  <= '0;
         r_m_p1   <= '0;
         r_wb_p1  <= '0;
         r_m_p2   <= '0;
         r_wb_p2  <= '0;
         r_wb_p3  <= '0;
         r_ill_p1 <= 1'b0;
      end else begin
         // ID -> ID/EX
         if (w_bubble) begin
            r_ex_p1 <= '0;
            r_m_p1  <= '0;
            r_wb_p1 <= '0;
         end else begin
            r_ex_p1 <= w_ex;
            r_m_p1  <= w_m;
            r_wb_p1 <= w_wb;
         end
         r_ill_p1 <= id_valid && !w_legal && !flush;
         // ID/EX -> EX/MEM
         if (FLUSH_EX && flush) begin
            r_m_p2  <= '0;
            r_wb_p2 <= '0;
         end else begin
            r_m_p2  <= r_m_p1;
            r_wb_p2 <= r_wb_p1;
         end
         // EX/MEM -> MEM/WB
         r_wb_p3 <= r_wb_p2;
      end
   end

   assign ex_ctrl  = r_ex_p1;
   assign mem_ctrl = r_m_p2;
   assign wb_ctrl  = r_wb_p3;
   assign ill_op   = r_ill_p1;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: directed cycle table followed by randomized traffic
// checked against an instruction-history reference model.
module tb_control_pipe;
   import ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst, id_valid, flush;
   logic [5:0] id_op;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic [4:0] ex_ctrl, mem_ctrl;
   logic [1:0] wb_ctrl;
   logic       stall, ill_op;

   always #5 clk = ~clk;

   control_pipe #(.REG_AW(5), .HAZARD_EN(1'b1), .FLUSH_EX(1'b1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .flush(flush),
      .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
      .stall(stall), .ill_op(ill_op)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       rst, vld;
      logic [5:0] op;
      logic [4:0] rs, rt, xrt;
      logic       fl, st;
      logic [4:0] ex, m;
      logic [1:0] wb;
      logic       ill;
   } row_t;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] ex, m;
      logic [1:0] wb;
   } dec_t;

   row_t rows[$];
   dec_t dtab[11];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Applies one cycle of inputs; returns stall mid-cycle and registered outputs after the edge
   task automatic run_cycle(input logic r, v, input logic [5:0] op, input logic [4:0] rs, rt, xrt,
                            input logic fl, output logic st, output logic [4:0] ex, m,
                            output logic [1:0] wb, output logic ill);
      rst = r; id_valid = v; id_op = op; id_rs = rs; id_rt = rt; ex_rt = xrt; flush = fl;
      #3 st = stall;
      @(posedge clk);
      #1;
      ex = ex_ctrl; m = mem_ctrl; wb = wb_ctrl; ill = ill_op;
   endtask

   // Spec decode table lookup; anything absent is illegal and decodes to zero
   task automatic ref_decode(input logic [5:0] op, output logic legal, output logic [4:0] ex, m,
                             output logic [1:0] wb, output logic urs, output logic urt);
      legal = 1'b0; ex = '0; m = '0; wb = '0;
      for (int k = 0; k < 11; k++)
         if (dtab[k].op == op) begin
            legal = 1'b1; ex = dtab[k].ex; m = dtab[k].m; wb = dtab[k].wb;
         end
      urs = legal && op != OP_J && op != OP_LUI;
      urt = op == OP_R || op == OP_SW || op == OP_BEQ || op == OP_BNE;
   endtask

   localparam int NR = 1500;
   logic [4:0] iss_e[NR];
   logic [4:0] iss_m[NR];
   logic [1:0] iss_w[NR];
   logic       rst_h[NR];
   logic       fl_h[NR];

   initial begin
      logic       st, ill, r, v, fl, legal, urs, urt, hz;
      logic [4:0] ex, m, dex, dm, rs, rt, xrt, e_m;
      logic [1:0] wb, dwb, e_w;
      logic [5:0] op;

      dtab[0]  = '{OP_R,    5'b10100, 5'b00000, 2'b10};
      dtab[1]  = '{OP_LW,   5'b00001, 5'b00100, 2'b11};
      dtab[2]  = '{OP_SW,   5'b00001, 5'b00010, 2'b00};
      dtab[3]  = '{OP_BEQ,  5'b00010, 5'b10000, 2'b00};
      dtab[4]  = '{OP_BNE,  5'b00010, 5'b11000, 2'b00};
      dtab[5]  = '{OP_ADDI, 5'b00001, 5'b00000, 2'b10};
      dtab[6]  = '{OP_SLTI, 5'b00111, 5'b00000, 2'b10};
      dtab[7]  = '{OP_ANDI, 5'b01011, 5'b00000, 2'b10};
      dtab[8]  = '{OP_ORI,  5'b01001, 5'b00000, 2'b10};
      dtab[9]  = '{OP_LUI,  5'b01101, 5'b00000, 2'b10};
      dtab[10] = '{OP_J,    5'b00000, 5'b00001, 2'b00};

      //               rst vld op       rs rt xrt fl  st ex        m         wb     ill
      rows.push_back('{1'b1, 1'b1, OP_LW,   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b1, 1'b1, OP_LW,   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_LW,   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_ADDI, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'b00001, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b10, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_LW,   5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 5'b00001, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_R,    5'd8, 5'd9, 5'd8, 1'b0, 1'b1, 5'b00000, 5'b00100, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_R,    5'd8, 5'd9, 5'd8, 1'b0, 1'b0, 5'b10100, 5'b00000, 2'b11, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_R,    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_R,    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b10, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_LW,   5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 5'b00001, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_LUI,  5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 5'b01101, 5'b00100, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_LW,   5'd1, 5'd0, 5'd8, 1'b0, 1'b0, 5'b00001, 5'b00000, 2'b11, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_R,    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b10100, 5'b00100, 2'b10, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_R,    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b11, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_LW,   5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 5'b00001, 5'b00000, 2'b10, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_R,    5'd5, 5'd6, 5'd5, 1'b1, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_BNE,  5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'b00010, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_ADDI, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_BNE,  5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'b00010, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_BNE,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b11000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_BNE,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, 6'h3f,   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b1});
      rows.push_back('{1'b0, 1'b0, 6'h3f,   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, 6'h3f,   5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, 6'h3f,   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b1, OP_J,    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_J,    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00001, 2'b00, 1'b0});
      rows.push_back('{1'b0, 1'b0, OP_J,    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 1'b0});

      rst = 1'b1; id_valid = 1'b0; id_op = '0; id_rs = '0; id_rt = '0; ex_rt = '0; flush = 1'b0;
      @(posedge clk);
      #1;

      foreach (rows[i]) begin
         run_cycle(rows[i].rst, rows[i].vld, rows[i].op, rows[i].rs, rows[i].rt, rows[i].xrt,
                   rows[i].fl, st, ex, m, wb, ill);
         check($sformatf("row%0d stall", i), st, rows[i].st);
         check($sformatf("row%0d ex_ctrl", i), ex, rows[i].ex);
         check($sformatf("row%0d mem_ctrl", i), m, rows[i].m);
         check($sformatf("row%0d wb_ctrl", i), wb, rows[i].wb);
         check($sformatf("row%0d ill_op", i), ill, rows[i].ill);
      end

      // Random traffic: small register range makes hazards frequent
      for (int n = 0; n < NR; n++) begin
         r   = (n < 2) || ($urandom_range(0, 49) == 0);
         v   = $urandom_range(0, 4) != 0;
         fl  = $urandom_range(0, 9) == 0;
         op  = ($urandom_range(0, 3) != 0) ? dtab[$urandom_range(0, 10)].op : 6'($urandom);
         rs  = 5'($urandom_range(0, 3));
         rt  = 5'($urandom_range(0, 3));
         xrt = 5'($urandom_range(0, 3));
         ref_decode(op, legal, dex, dm, dwb, urs, urt);
         hz = 1'b0;
         if (n > 0)
            hz = v && iss_m[n-1][M_MEMREAD] && xrt != 0 && ((urs && xrt == rs) || (urt && xrt == rt));
         rst_h[n] = r;
         fl_h[n]  = fl;
         if (r || fl || hz || !v) begin
            iss_e[n] = '0; iss_m[n] = '0; iss_w[n] = '0;
         end else begin
            iss_e[n] = dex; iss_m[n] = dm; iss_w[n] = dwb;
         end
         e_m = '0;
         if (n >= 1 && !r && !fl) e_m = iss_m[n-1];
         e_w = '0;
         if (n >= 2 && !r && !rst_h[n-1] && !fl_h[n-1]) e_w = iss_w[n-2];
         run_cycle(r, v, op, rs, rt, xrt, fl, st, ex, m, wb, ill);
         check($sformatf("rnd%0d stall", n), st, hz && !fl && !r);
         check($sformatf("rnd%0d ex_ctrl", n), ex, iss_e[n]);
         check($sformatf("rnd%0d mem_ctrl", n), m, e_m);
         check($sformatf("rnd%0d wb_ctrl", n), wb, e_w);
         check($sformatf("rnd%0d ill_op", n), ill, !r && v && !legal && !fl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
